// File: rtl/warp_ctx_reg_file_pkg.sv
// Shared types and constants for the multi-warp register file.
// DATA_WIDTH defaults to 32 when the `DATA_WIDTH macro is not supplied.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_ctx_reg_file_pkg;

  typedef logic [`DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_init_state_t;

  // Special registers sit at the top of the register map, counted down from NUM_REGS.
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned TID_OFS  = 3;
  localparam int unsigned BID_OFS  = 2;
  localparam int unsigned BSZ_OFS  = 1;

endpackage

// File: rtl/warp_ctx_reg_file_scoreboard.sv
// Per-warp pending-write scoreboard: one bit per (warp, register).
// Set wins over a same-cycle clear; R0 and special registers are never marked.
module rf_scoreboard
  import warp_ctx_reg_file_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         set_en,
  input  logic [$clog2(NUM_WARPS)-1:0] set_warp,
  input  logic [$clog2(NUM_REGS)-1:0]  set_reg,
  input  logic                         clr_en,
  input  logic [$clog2(NUM_WARPS)-1:0] clr_warp,
  input  logic [$clog2(NUM_REGS)-1:0]  clr_reg,
  input  logic                         init_en,
  input  logic [$clog2(NUM_WARPS)-1:0] init_warp,
  input  logic [$clog2(NUM_REGS)-1:0]  init_reg,
  input  logic [$clog2(NUM_WARPS)-1:0] lk_warp,
  input  logic [$clog2(NUM_REGS)-1:0]  lk_reg_a,
  input  logic [$clog2(NUM_REGS)-1:0]  lk_reg_b,
  output logic                         lk_pend_a,
  output logic                         lk_pend_b
);

  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0] TID_IDX = RW'(NUM_REGS - TID_OFS);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_q, pend_d;
  logic                               set_ok;

  // Next pending state: clears first, then issue-side set so it wins on collision.
  always_comb begin
    pend_d = pend_q;
    set_ok = set_en && (set_reg != RW'(ZERO_REG)) && (set_reg < TID_IDX);
    if (init_en) pend_d[init_warp][init_reg] = 1'b0;
    if (clr_en)  pend_d[clr_warp][clr_reg]   = 1'b0;
    if (set_ok)  pend_d[set_warp][set_reg]   = 1'b1;
  end

  // Pending-bit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign lk_pend_a = pend_q[lk_warp][lk_reg_a];
  assign lk_pend_b = pend_q[lk_warp][lk_reg_b];

endmodule

// File: rtl/warp_ctx_reg_file.sv
// Multi-warp register file with context-init engine, registered read port,
// masked write-back and pending-write scoreboard.
// Optional: define RF_WB_BYPASS_EN to forward same-cycle write-back data to reads.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_ctx_reg_file
  import warp_ctx_reg_file_pkg::*;
#(
  parameter int unsigned NUM_WARPS        = 4,
  parameter int unsigned THREADS_PER_WARP = 16,
  parameter int unsigned NUM_REGS         = 32,
  parameter int unsigned DATA_WIDTH       = `DATA_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]                     cfg_warp,
  input  logic [DATA_WIDTH-1:0]                            cfg_block_id,
  input  logic [DATA_WIDTH-1:0]                            cfg_block_size,
  input  logic                                             rd_req_valid,
  output logic                                             rd_req_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]                     rd_warp,
  input  logic [$clog2(NUM_REGS)-1:0]                      rd_rs1,
  input  logic [$clog2(NUM_REGS)-1:0]                      rd_rs2,
  input  logic [THREADS_PER_WARP-1:0]                      rd_mask,
  output logic                                             rd_resp_valid,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      rd_rs1_data,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      rd_rs2_data,
  output logic                                             rd_hazard,
  input  logic                                             sb_set,
  input  logic [$clog2(NUM_WARPS)-1:0]                     sb_warp,
  input  logic [$clog2(NUM_REGS)-1:0]                      sb_rd,
  input  logic                                             wb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]                     wb_warp,
  input  logic [$clog2(NUM_REGS)-1:0]                      wb_rd,
  input  logic [THREADS_PER_WARP-1:0]                      wb_mask,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0]      wb_data
);

  localparam int unsigned WW = $clog2(NUM_WARPS);
  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0] TID_IDX  = RW'(NUM_REGS - TID_OFS);
  localparam logic [RW-1:0] BID_IDX  = RW'(NUM_REGS - BID_OFS);
  localparam logic [RW-1:0] BSZ_IDX  = RW'(NUM_REGS - BSZ_OFS);
  localparam logic [RW-1:0] LAST_GPR = RW'(NUM_REGS - 4);

  typedef logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lanes_t;

  rf_init_state_t                                         state_q, state_d;
  logic [RW-1:0]                                          cnt_q, cnt_d;
  logic [WW-1:0]                                          init_warp_q, init_warp_d;
  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]                   bid_q, bid_d;
  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]                   bsz_q, bsz_d;
  logic [NUM_WARPS-1:0][THREADS_PER_WARP-1:0][NUM_REGS-1:0][DATA_WIDTH-1:0] gpr_q, gpr_d;

  logic   resp_valid_q, resp_valid_d;
  logic   hazard_q, hazard_d;
  lanes_t rs1_data_q, rs1_data_d;
  lanes_t rs2_data_q, rs2_data_d;
  lanes_t src1_val, src2_val;

  logic clearing, rd_accept, wb_live, wb_wr;
  logic sb_pend1, sb_pend2, pend1, pend2;

  // Select a lane's operand: special registers are synthesised, GPRs come from storage.
  function automatic logic [DATA_WIDTH-1:0] sel_val(
    input logic [RW-1:0]         rs,
    input logic [DATA_WIDTH-1:0] gpr,
    input logic [DATA_WIDTH-1:0] tid,
    input logic [DATA_WIDTH-1:0] bid,
    input logic [DATA_WIDTH-1:0] bsz
  );
    if (rs == RW'(ZERO_REG)) return '0;
    if (rs == TID_IDX)       return tid;
    if (rs == BID_IDX)       return bid;
    if (rs == BSZ_IDX)       return bsz;
    return gpr;
  endfunction

  assign clearing     = (state_q == RF_CLEAR);
  assign cfg_ready    = (state_q == RF_IDLE);
  assign rd_req_ready = (state_q == RF_IDLE);
  assign rd_accept    = rd_req_valid && rd_req_ready;
  // Write-back to the context being cleared is dropped, pending clear included.
  assign wb_live      = wb_valid && !(clearing && (wb_warp == init_warp_q));
  assign wb_wr        = wb_live && (wb_rd != RW'(ZERO_REG)) && (wb_rd < TID_IDX);

  rf_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (sb_set),
    .set_warp  (sb_warp),
    .set_reg   (sb_rd),
    .clr_en    (wb_live),
    .clr_warp  (wb_warp),
    .clr_reg   (wb_rd),
    .init_en   (clearing),
    .init_warp (init_warp_q),
    .init_reg  (cnt_q),
    .lk_warp   (rd_warp),
    .lk_reg_a  (rd_rs1),
    .lk_reg_b  (rd_rs2),
    .lk_pend_a (sb_pend1),
    .lk_pend_b (sb_pend2)
  );

  // Hazard sees the same-cycle write-back clear but not the same-cycle issue set.
  assign pend1 = sb_pend1 && !(wb_live && (wb_warp == rd_warp) && (wb_rd == rd_rs1));
  assign pend2 = sb_pend2 && !(wb_live && (wb_warp == rd_warp) && (wb_rd == rd_rs2));

  // Init engine next state: accept a context, then sweep GPR 1..NUM_REGS-4.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_warp_d = init_warp_q;
    bid_d       = bid_q;
    bsz_d       = bsz_q;
    unique case (state_q)
      RF_IDLE: begin
        if (cfg_valid) begin
          state_d           = RF_CLEAR;
          cnt_d             = RW'(1);
          init_warp_d       = cfg_warp;
          bid_d[cfg_warp]   = cfg_block_id;
          bsz_d[cfg_warp]   = cfg_block_size;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + RW'(1);
        if (cnt_q == LAST_GPR) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // GPR storage update: init sweep and masked write-back never target the same warp.
  always_comb begin
    gpr_d = gpr_q;
    for (int unsigned t = 0; t < THREADS_PER_WARP; t++) begin
      if (clearing) gpr_d[init_warp_q][t][cnt_q] = '0;
      if (wb_wr && wb_mask[t]) gpr_d[wb_warp][t][wb_rd] = wb_data[t];
    end
  end

  // Per-lane operand values for the current read request.
  always_comb begin
    src1_val = '0;
    src2_val = '0;
    for (int unsigned t = 0; t < THREADS_PER_WARP; t++) begin
      logic [DATA_WIDTH-1:0] tid, g1, g2;
      tid = DATA_WIDTH'(32'(rd_warp) * THREADS_PER_WARP + t);
      g1  = gpr_q[rd_warp][t][rd_rs1];
      g2  = gpr_q[rd_warp][t][rd_rs2];
`ifdef RF_WB_BYPASS_EN
      if (wb_wr && (wb_warp == rd_warp) && (wb_rd == rd_rs1) && wb_mask[t]) g1 = wb_data[t];
      if (wb_wr && (wb_warp == rd_warp) && (wb_rd == rd_rs2) && wb_mask[t]) g2 = wb_data[t];
`endif
      src1_val[t] = sel_val(rd_rs1, g1, tid, bid_q[rd_warp], bsz_q[rd_warp]);
      src2_val[t] = sel_val(rd_rs2, g2, tid, bid_q[rd_warp], bsz_q[rd_warp]);
    end
  end

  // Read response: one-cycle valid pulse, masked-off lanes hold.
  always_comb begin
    resp_valid_d = rd_accept;
    hazard_d     = rd_accept && (pend1 || pend2);
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    for (int unsigned t = 0; t < THREADS_PER_WARP; t++) begin
      if (rd_accept && rd_mask[t]) begin
        rs1_data_d[t] = src1_val[t];
        rs2_data_d[t] = src2_val[t];
      end
    end
  end

  // All state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RF_IDLE;
      cnt_q        <= '0;
      init_warp_q  <= '0;
      bid_q        <= '0;
      bsz_q        <= '0;
      gpr_q        <= '0;
      resp_valid_q <= 1'b0;
      hazard_q     <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_warp_q  <= init_warp_d;
      bid_q        <= bid_d;
      bsz_q        <= bsz_d;
      gpr_q        <= gpr_d;
      resp_valid_q <= resp_valid_d;
      hazard_q     <= hazard_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
    end
  end

  assign rd_resp_valid = resp_valid_q;
  assign rd_hazard     = hazard_q;
  assign rd_rs1_data   = rs1_data_q;
  assign rd_rs2_data   = rs2_data_q;

endmodule

// File: tb/tb_warp_ctx_reg_file.sv
// Self-checking bench for warp_ctx_reg_file: directed steps plus a randomized
// phase, compared against a behavioural model of contexts and pending bits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_warp_ctx_reg_file;

  localparam int NW = 4;
  localparam int T  = 16;
  localparam int NR = 32;
  localparam int DW = `DATA_WIDTH;
  localparam int WW = $clog2(NW);
  localparam int RW = $clog2(NR);

  typedef logic [T-1:0][DW-1:0] lanes_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cfg_valid, cfg_ready;
  logic [WW-1:0] cfg_warp;
  logic [DW-1:0] cfg_block_id, cfg_block_size;
  logic          rd_req_valid, rd_req_ready;
  logic [WW-1:0] rd_warp;
  logic [RW-1:0] rd_rs1, rd_rs2;
  logic [T-1:0]  rd_mask;
  logic          rd_resp_valid, rd_hazard;
  lanes_t        rd_rs1_data, rd_rs2_data;
  logic          sb_set;
  logic [WW-1:0] sb_warp;
  logic [RW-1:0] sb_rd;
  logic          wb_valid;
  logic [WW-1:0] wb_warp;
  logic [RW-1:0] wb_rd;
  logic [T-1:0]  wb_mask;
  lanes_t        wb_data;

  always #5 clk = ~clk;

  warp_ctx_reg_file #(
    .NUM_WARPS        (NW),
    .THREADS_PER_WARP (T),
    .NUM_REGS         (NR),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_warp       (cfg_warp),
    .cfg_block_id   (cfg_block_id),
    .cfg_block_size (cfg_block_size),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_warp        (rd_warp),
    .rd_rs1         (rd_rs1),
    .rd_rs2         (rd_rs2),
    .rd_mask        (rd_mask),
    .rd_resp_valid  (rd_resp_valid),
    .rd_rs1_data    (rd_rs1_data),
    .rd_rs2_data    (rd_rs2_data),
    .rd_hazard      (rd_hazard),
    .sb_set         (sb_set),
    .sb_warp        (sb_warp),
    .sb_rd          (sb_rd),
    .wb_valid       (wb_valid),
    .wb_warp        (wb_warp),
    .wb_rd          (wb_rd),
    .wb_mask        (wb_mask),
    .wb_data        (wb_data)
  );

  // Reference model state
  logic [DW-1:0] m_gpr [NW][T][NR];
  logic [DW-1:0] m_bid [NW];
  logic [DW-1:0] m_bsz [NW];
  bit            m_pend [NW][NR];
  int            m_busy;
  int            m_busy_warp;
  lanes_t        e_rs1, e_rs2;

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input lanes_t obs, input lanes_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_gpr(input int r);
    return (r >= 1) && (r <= NR - 4);
  endfunction

  function automatic logic [DW-1:0] m_val(input int w, input int lane, input int r);
    if (r == 0)      return '0;
    if (r == NR - 3) return DW'(w * T + lane);
    if (r == NR - 2) return m_bid[w];
    if (r == NR - 1) return m_bsz[w];
    return m_gpr[w][lane][r];
  endfunction

  task automatic m_reset();
    for (int w = 0; w < NW; w++) begin
      m_bid[w] = '0;
      m_bsz[w] = '0;
      for (int r = 0; r < NR; r++) begin
        m_pend[w][r] = 1'b0;
        for (int l = 0; l < T; l++) m_gpr[w][l][r] = '0;
      end
    end
    m_busy      = 0;
    m_busy_warp = 0;
    e_rs1       = '0;
    e_rs2       = '0;
  endtask

  task automatic idle();
    cfg_valid      = 1'b0;
    cfg_warp       = '0;
    cfg_block_id   = '0;
    cfg_block_size = '0;
    rd_req_valid   = 1'b0;
    rd_warp        = '0;
    rd_rs1         = '0;
    rd_rs2         = '0;
    rd_mask        = '0;
    sb_set         = 1'b0;
    sb_warp        = '0;
    sb_rd          = '0;
    wb_valid       = 1'b0;
    wb_warp        = '0;
    wb_rd          = '0;
    wb_mask        = '0;
    wb_data        = '0;
  endtask

  // One clock: predict from current inputs and model, advance, then compare.
  task automatic tick();
    bit            acc_rd, acc_cfg, live, haz, p1, p2;
    int            w, r1, r2;
    logic [DW-1:0] v1, v2;
    acc_rd  = rd_req_valid && (m_busy == 0);
    acc_cfg = cfg_valid && (m_busy == 0);
    live    = wb_valid && !((m_busy > 0) && (int'(wb_warp) == m_busy_warp));
    haz     = 1'b0;
    if (acc_rd) begin
      w  = int'(rd_warp);
      r1 = int'(rd_rs1);
      r2 = int'(rd_rs2);
      for (int l = 0; l < T; l++) begin
        if (rd_mask[l]) begin
          v1 = m_val(w, l, r1);
          v2 = m_val(w, l, r2);
`ifdef RF_WB_BYPASS_EN
          if (live && m_is_gpr(r1) && int'(wb_warp) == w && int'(wb_rd) == r1 && wb_mask[l]) v1 = wb_data[l];
          if (live && m_is_gpr(r2) && int'(wb_warp) == w && int'(wb_rd) == r2 && wb_mask[l]) v2 = wb_data[l];
`endif
          e_rs1[l] = v1;
          e_rs2[l] = v2;
        end
      end
      p1  = m_pend[w][r1] && !(live && int'(wb_warp) == w && int'(wb_rd) == r1);
      p2  = m_pend[w][r2] && !(live && int'(wb_warp) == w && int'(wb_rd) == r2);
      haz = p1 || p2;
    end
    if (live) begin
      m_pend[wb_warp][wb_rd] = 1'b0;
      if (m_is_gpr(int'(wb_rd)))
        for (int l = 0; l < T; l++) if (wb_mask[l]) m_gpr[wb_warp][l][wb_rd] = wb_data[l];
    end
    if (sb_set && m_is_gpr(int'(sb_rd))) m_pend[sb_warp][sb_rd] = 1'b1;
    if (m_busy > 0) m_busy--;
    if (acc_cfg) begin
      m_busy      = NR - 4;
      m_busy_warp = int'(cfg_warp);
      m_bid[cfg_warp] = cfg_block_id;
      m_bsz[cfg_warp] = cfg_block_size;
      for (int r = 0; r < NR; r++) begin
        m_pend[cfg_warp][r] = 1'b0;
        for (int l = 0; l < T; l++) m_gpr[cfg_warp][l][r] = '0;
      end
    end
    @(posedge clk);
    #1;
    chk1("resp_valid", rd_resp_valid, acc_rd);
    if (acc_rd) chk1("hazard", rd_hazard, haz);
    chkd("rs1_data", rd_rs1_data, e_rs1);
    chkd("rs2_data", rd_rs2_data, e_rs2);
    chk1("cfg_ready", cfg_ready, m_busy == 0);
    chk1("rd_req_ready", rd_req_ready, m_busy == 0);
  endtask

  task automatic read(input int w, input int r1, input int r2, input logic [T-1:0] mask);
    idle();
    rd_req_valid = 1'b1;
    rd_warp      = WW'(w);
    rd_rs1       = RW'(r1);
    rd_rs2       = RW'(r2);
    rd_mask      = mask;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    chk1({tag, "_rd_req_ready"}, rd_req_ready, 1'b1);
    chk1({tag, "_resp_valid"}, rd_resp_valid, 1'b0);
    chk1({tag, "_hazard"}, rd_hazard, 1'b0);
    chkd({tag, "_rs1_data"}, rd_rs1_data, '0);
    chkd({tag, "_rs2_data"}, rd_rs2_data, '0);
  endtask

  initial begin
    lanes_t ev;
    int     low;
    idle();
    m_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Thread-id register of warp 2 and an unconfigured block id
    read(2, NR - 3, NR - 2, '1);
    tick();
    for (int i = 0; i < T; i++) ev[i] = DW'(32 + i);
    chkd("tid_warp2", rd_rs1_data, ev);
    chkd("bid_warp2", rd_rs2_data, '0);
    idle();
    tick();

    // Context init of warp 1; reads are held off while it runs
    idle();
    cfg_valid      = 1'b1;
    cfg_warp       = WW'(1);
    cfg_block_id   = DW'(7);
    cfg_block_size = DW'(64);
    tick();
    read(1, NR - 2, NR - 1, '1);
    low = cfg_ready ? 0 : 1;
    for (int k = 0; k < 100 && !cfg_ready; k++) begin
      tick();
      if (!cfg_ready) low++;
    end
    chk32("cfg_busy_cycles", low, NR - 4);
    tick();
    for (int i = 0; i < T; i++) ev[i] = DW'(7);
    chkd("bid_warp1", rd_rs1_data, ev);
    for (int i = 0; i < T; i++) ev[i] = DW'(64);
    chkd("bsz_warp1", rd_rs2_data, ev);
    read(1, 5, NR - 3, '1);
    tick();
    chkd("gpr5_warp1", rd_rs1_data, '0);

    // Masked write-back, then writes to R0 and the thread-id register
    idle();
    wb_valid = 1'b1;
    wb_warp  = '0;
    wb_rd    = RW'(5);
    wb_mask  = T'(16'h00FF);
    for (int i = 0; i < T; i++) wb_data[i] = DW'(i * 3);
    tick();
    read(0, 5, 5, '1);
    tick();
    for (int i = 0; i < T; i++) ev[i] = (i < 8) ? DW'(i * 3) : '0;
    chkd("wb_masked_r5", rd_rs1_data, ev);
    idle();
    wb_valid = 1'b1;
    wb_mask  = '1;
    for (int i = 0; i < T; i++) wb_data[i] = DW'(32'h55);
    wb_rd = '0;
    tick();
    wb_rd = RW'(NR - 3);
    tick();
    read(0, 0, NR - 3, '1);
    tick();
    chkd("wb_r0_ignored", rd_rs1_data, '0);
    for (int i = 0; i < T; i++) ev[i] = DW'(i);
    chkd("wb_tid_ignored", rd_rs2_data, ev);

    // Scoreboard set, clear, and set-over-clear collision
    idle();
    sb_set = 1'b1; sb_warp = WW'(3); sb_rd = RW'(4);
    tick();
    read(3, 4, 0, '1);
    tick();
    chk1("haz_after_set", rd_hazard, 1'b1);
    idle();
    wb_valid = 1'b1; wb_warp = WW'(3); wb_rd = RW'(4); wb_mask = '1;
    tick();
    read(3, 4, 0, '1);
    tick();
    chk1("haz_after_wb", rd_hazard, 1'b0);
    idle();
    sb_set = 1'b1; sb_warp = WW'(3); sb_rd = RW'(4);
    wb_valid = 1'b1; wb_warp = WW'(3); wb_rd = RW'(4); wb_mask = '1;
    tick();
    read(3, 0, 4, '1);
    tick();
    chk1("haz_set_wins", rd_hazard, 1'b1);

    // Same-cycle write-back and read of warp 0 R6
    idle();
    sb_set = 1'b1; sb_warp = '0; sb_rd = RW'(6);
    wb_valid = 1'b1; wb_warp = '0; wb_rd = RW'(6); wb_mask = '1;
    for (int i = 0; i < T; i++) wb_data[i] = DW'(32'h11);
    tick();
    idle();
    sb_set = 1'b1; sb_warp = '0; sb_rd = RW'(6);
    tick();
    read(0, 6, 6, '1);
    wb_valid = 1'b1; wb_warp = '0; wb_rd = RW'(6); wb_mask = '1;
    for (int i = 0; i < T; i++) wb_data[i] = DW'(32'hAA);
    tick();
`ifdef RF_WB_BYPASS_EN
    for (int i = 0; i < T; i++) ev[i] = DW'(32'hAA);
`else
    for (int i = 0; i < T; i++) ev[i] = DW'(32'h11);
`endif
    chkd("same_cycle_rw", rd_rs1_data, ev);
    chk1("same_cycle_haz", rd_hazard, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      idle();
      cfg_valid      = ($urandom_range(0, 39) == 0);
      cfg_warp       = WW'($urandom);
      cfg_block_id   = DW'($urandom);
      cfg_block_size = DW'($urandom);
      rd_req_valid   = 1'($urandom_range(0, 1));
      rd_warp        = WW'($urandom);
      rd_rs1         = ($urandom_range(0, 1) == 1) ? RW'($urandom_range(0, 7)) : RW'($urandom);
      rd_rs2         = ($urandom_range(0, 1) == 1) ? RW'($urandom_range(0, 7)) : RW'($urandom);
      rd_mask        = T'($urandom);
      wb_valid       = 1'($urandom_range(0, 1));
      wb_warp        = WW'($urandom);
      wb_rd          = RW'($urandom_range(0, 9));
      wb_mask        = T'($urandom);
      for (int l = 0; l < T; l++) wb_data[l] = DW'($urandom);
      sb_set         = ($urandom_range(0, 2) == 0);
      sb_warp        = WW'($urandom);
      sb_rd          = RW'($urandom_range(0, 9));
      if (m_busy > 0 && int'(sb_warp) == m_busy_warp) sb_set = 1'b0;
      tick();
    end

    // Reset in the middle of a context clear
    idle();
    for (int k = 0; k < 100 && m_busy > 0; k++) tick();
    cfg_valid = 1'b1; cfg_warp = WW'(2); cfg_block_id = DW'(9); cfg_block_size = DW'(128);
    tick();
    idle();
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    m_reset();
    check_reset_outputs("mid_clear_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int w = 0; w < NW; w++) begin
      read(w, $urandom_range(1, NR - 4), NR - 2, '1);
      tick();
      read(w, 5, NR - 1, '1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
